// File: rtl/ps2_ascii_fsm_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
// Holds the decoder state enum, the prefix byte values and the set-2 to ASCII letter map.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAKE,
    BREAK,
    EXT,
    EXT_BREAK
  } ps2_state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  // Returned for unmapped codes; never a letter, so it doubles as "not a key".
  localparam logic [7:0] NO_ASCII   = 8'h00;

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C:   a = 8'h41;
      8'h32:   a = 8'h42;
      8'h21:   a = 8'h43;
      8'h23:   a = 8'h44;
      8'h24:   a = 8'h45;
      8'h2B:   a = 8'h46;
      8'h34:   a = 8'h47;
      8'h33:   a = 8'h48;
      8'h43:   a = 8'h49;
      8'h3B:   a = 8'h4A;
      8'h42:   a = 8'h4B;
      8'h4B:   a = 8'h4C;
      8'h3A:   a = 8'h4D;
      8'h31:   a = 8'h4E;
      8'h44:   a = 8'h4F;
      8'h4D:   a = 8'h50;
      8'h15:   a = 8'h51;
      8'h2D:   a = 8'h52;
      8'h1B:   a = 8'h53;
      8'h2C:   a = 8'h54;
      8'h3C:   a = 8'h55;
      8'h2A:   a = 8'h56;
      8'h1D:   a = 8'h57;
      8'h22:   a = 8'h58;
      8'h35:   a = 8'h59;
      8'h1A:   a = 8'h5A;
      default: a = NO_ASCII;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ps2_ascii_fsm_if.sv
// Keyboard-side bundle: raw PS/2 lines in, decoded held-key ASCII out.
// slave is the decoder; master is whatever drives the keyboard lines and consumes ascii.
interface ps2_ascii_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ascii;
  logic       key_down;

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output ascii,
    output key_down
  );

  modport master (
    output ps2_clk,
    output ps2_data,
    input  ascii,
    input  key_down
  );
endinterface

// File: rtl/ps2_ascii_fsm_rx.sv
// PS/2 frame receiver: synchronizes the keyboard lines, samples data on ps2_clk falling
// edges and emits one-cycle byte_valid strobes for frames with good start, parity and stop.
module ps2_rx #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid
);

  logic [2:0]  clk_sync;
  logic [2:0]  data_sync;
  logic        clk_prev;
  logic        fall;
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;
  logic [15:0] to_cnt;
  logic [10:0] frame;

  assign fall  = clk_prev & ~clk_sync[2];
  // Completed frame as seen on the stop-bit edge: [0] start, [8:1] data, [9] parity, [10] stop.
  assign frame = {data_sync[2], shreg};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      // Idle-high reset values keep the first real edge after release from being missed or faked.
      clk_sync   <= 3'b111;
      data_sync  <= 3'b111;
      clk_prev   <= 1'b1;
      bit_cnt    <= 4'd0;
      shreg      <= 10'd0;
      to_cnt     <= TIMEOUT;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ps2_clk};
      data_sync  <= {data_sync[1:0], ps2_data};
      clk_prev   <= clk_sync[2];
      byte_valid <= 1'b0;
      if (fall) begin
        to_cnt <= TIMEOUT;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (!frame[0] && frame[10] && (^frame[9:1])) begin
            rx_byte    <= frame[8:1];
            byte_valid <= 1'b1;
          end
        end else begin
          shreg   <= {data_sync[2], shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == 16'd0) begin
          bit_cnt <= 4'd0;
          to_cnt  <= TIMEOUT;
        end else begin
          to_cnt <= to_cnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_ascii_fsm.sv
// PS/2 keyboard front end: tracks make/break/extended sequences and presents the
// ASCII letter of the key currently held, resting at IDLE_ASCII when none is held.
module ps2_ascii_fsm
  import ps2_pkg::*;
#(
  parameter logic [7:0]  IDLE_ASCII = 8'h31,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input logic      clk,
  input logic      clrn,
  ps2_ascii_if.slave kbd
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic [7:0] code_ascii;

  ps2_state_t state;
  logic [7:0] held;
  logic [7:0] ascii_q;
  logic       key_down_q;

  ps2_rx #(
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (kbd.ps2_clk),
    .ps2_data   (kbd.ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid)
  );

  assign code_ascii = scan_to_ascii(rx_byte);

  // key_down_q doubles as the "held code valid" flag that selects the return state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      held       <= 8'h00;
      ascii_q    <= IDLE_ASCII;
      key_down_q <= 1'b0;
    end else if (byte_valid) begin
      case (state)
        IDLE, MAKE: begin
          if (rx_byte == BREAK_CODE) begin
            state <= BREAK;
          end else if (rx_byte == EXT_CODE) begin
            state <= EXT;
          end else if (code_ascii != NO_ASCII) begin
            held       <= rx_byte;
            ascii_q    <= code_ascii;
            key_down_q <= 1'b1;
            state      <= MAKE;
          end
        end
        BREAK: begin
          if (rx_byte == held) begin
            state      <= IDLE;
            held       <= 8'h00;
            ascii_q    <= IDLE_ASCII;
            key_down_q <= 1'b0;
          end else begin
            state <= key_down_q ? MAKE : IDLE;
          end
        end
        EXT: begin
          if (rx_byte == BREAK_CODE) state <= EXT_BREAK;
          else                       state <= key_down_q ? MAKE : IDLE;
        end
        EXT_BREAK: state <= key_down_q ? MAKE : IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign kbd.ascii    = ascii_q;
  assign kbd.key_down = key_down_q;

endmodule

// File: tb/tb_ps2_ascii_fsm.sv
// Bench for ps2_ascii_fsm: bit-level PS/2 frame driver, a key-tracking model and a
// per-cycle compare of ascii/key_down, plus directed literal expectations.
module tb_ps2_ascii_fsm;

  localparam logic [7:0] IDLE_A = 8'h31;
  localparam int         TO     = 200;
  localparam int         H      = 16;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  ps2_ascii_if kbd ();

  ps2_ascii_fsm #(
    .IDLE_ASCII (IDLE_A),
    .TIMEOUT    (16'(TO))
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .kbd  (kbd)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model: which letter code is held (-1 none) and which prefix bytes are pending.
  int m_held  = -1;
  bit m_brk   = 1'b0;
  bit m_ext   = 1'b0;
  bit m_extbk = 1'b0;

  logic [7:0] codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
                             8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  function automatic int letter_of(input logic [7:0] b);
    for (int i = 0; i < 26; i++)
      if (codes[i] == b) return 8'h41 + i;
    return -1;
  endfunction

  function automatic logic [7:0] exp_ascii();
    if (m_held < 0) return IDLE_A;
    return 8'(letter_of(8'(m_held)));
  endfunction

  function automatic logic exp_down();
    return m_held >= 0;
  endfunction

  function automatic void model_reset();
    m_held  = -1;
    m_brk   = 1'b0;
    m_ext   = 1'b0;
    m_extbk = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (m_ext) begin
      if (b == 8'hF0 && !m_extbk) m_extbk = 1'b1;
      else begin
        m_ext   = 1'b0;
        m_extbk = 1'b0;
      end
    end else if (m_brk) begin
      m_brk = 1'b0;
      if (m_held >= 0 && int'(b) == m_held) m_held = -1;
    end else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (letter_of(b) >= 0) m_held = int'(b);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("ascii_vs_model", kbd.ascii, exp_ascii());
      check("key_down_vs_model", {7'b0, kbd.key_down}, {7'b0, exp_down()});
    end
  end

  // err: 0 good, 1 bad parity, 2 bad start, 3 bad stop. lat pins the 5-cycle output latency.
  task automatic send_frame(input logic [7:0] b, input int err, input bit lat);
    logic [10:0] f;
    logic [7:0]  old_a;
    f = {1'b1, ~^b, b, 1'b0};
    if (err == 1) f[9] = ~f[9];
    if (err == 2) f[0] = 1'b1;
    if (err == 3) f[10] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      kbd.ps2_data = f[i];
      repeat (H) @(negedge clk);
      if (i == 10) begin
        old_a = exp_ascii();
        check_en = 1'b0;
        kbd.ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        if (lat) check("latency_before", kbd.ascii, old_a);
        @(negedge clk);
        if (err == 0) model_byte(b);
        if (lat) check("latency_after", kbd.ascii, exp_ascii());
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        repeat (H - 8) @(negedge clk);
      end else begin
        kbd.ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
      end
      kbd.ps2_clk = 1'b1;
    end
    kbd.ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      kbd.ps2_data = f[i];
      repeat (H) @(negedge clk);
      kbd.ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      kbd.ps2_clk = 1'b1;
    end
    kbd.ps2_data = 1'b1;
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    clrn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ascii", kbd.ascii, 8'h31);
    check("reset_key_down", {7'b0, kbd.key_down}, 8'h00);
    clrn = 1'b1;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] a, input logic d);
    check({name, "_ascii"}, kbd.ascii, a);
    check({name, "_key_down"}, {7'b0, kbd.key_down}, {7'b0, d});
  endtask

  initial begin
    int r;
    int err;
    logic [7:0] b;
    kbd.ps2_clk  = 1'b1;
    kbd.ps2_data = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    send_frame(8'h1C, 0, 1'b1);
    expect_out("first_make", 8'h41, 1'b1);

    for (int i = 0; i < 3; i++) begin
      send_frame(8'h1C, 0, 1'b0);
      expect_out("typematic", 8'h41, 1'b1);
    end
    send_frame(8'hF0, 0, 1'b0);
    expect_out("break_prefix", 8'h41, 1'b1);
    send_frame(8'h1C, 0, 1'b0);
    expect_out("release_a", 8'h31, 1'b0);

    send_frame(8'h1C, 0, 1'b0);
    send_frame(8'h32, 0, 1'b0);
    expect_out("replace_b", 8'h42, 1'b1);
    send_frame(8'hF0, 0, 1'b0);
    send_frame(8'h1C, 0, 1'b0);
    expect_out("stale_break", 8'h42, 1'b1);
    send_frame(8'hF0, 0, 1'b0);
    send_frame(8'h32, 0, 1'b0);
    expect_out("release_b", 8'h31, 1'b0);

    send_frame(8'h1C, 1, 1'b0);
    expect_out("bad_parity", 8'h31, 1'b0);
    send_frame(8'h1C, 2, 1'b0);
    expect_out("bad_start", 8'h31, 1'b0);
    send_frame(8'h1C, 3, 1'b0);
    expect_out("bad_stop", 8'h31, 1'b0);
    send_frame(8'h1C, 0, 1'b0);
    expect_out("after_bad", 8'h41, 1'b1);
    send_frame(8'hF0, 0, 1'b0);
    send_frame(8'h1C, 0, 1'b0);

    send_frame(8'hE0, 0, 1'b0);
    send_frame(8'h75, 0, 1'b0);
    expect_out("ext_make", 8'h31, 1'b0);
    send_frame(8'hE0, 0, 1'b0);
    send_frame(8'hF0, 0, 1'b0);
    send_frame(8'h75, 0, 1'b0);
    expect_out("ext_break", 8'h31, 1'b0);
    send_frame(8'h05, 0, 1'b0);
    expect_out("unmapped", 8'h31, 1'b0);
    send_frame(8'hE0, 0, 1'b0);
    send_frame(8'h1C, 0, 1'b0);
    expect_out("ext_letter_ignored", 8'h31, 1'b0);

    send_frame(8'h2C, 0, 1'b0);
    send_partial(8'h1C, 5);
    do_reset();
    repeat (2 * TO) @(negedge clk);
    send_frame(8'h1C, 0, 1'b0);
    expect_out("after_reset_abort", 8'h41, 1'b1);
    send_frame(8'hF0, 0, 1'b0);
    send_frame(8'h1C, 0, 1'b0);

    send_partial(8'h32, 5);
    repeat (2 * TO) @(negedge clk);
    send_frame(8'h1A, 0, 1'b0);
    expect_out("after_timeout", 8'h5A, 1'b1);

    for (int n = 0; n < 100; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45)      b = codes[$urandom_range(0, 25)];
      else if (r < 60) b = 8'hF0;
      else if (r < 68) b = 8'hE0;
      else if (r < 82) b = (m_held >= 0) ? 8'(m_held) : codes[$urandom_range(0, 25)];
      else             b = 8'($urandom_range(0, 255));
      err = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_frame(b, err, 1'b0);
    end

    check_en = 1'b0;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
